// File: rtl/memory_stage.sv
// Y86-64 memory stage: decodes the execute-stage op, checks the address and
// performs a fixed-latency load/store on a word-organised data memory behind
// a start/busy/done handshake. A preload port seeds memory while idle.
module memory_stage #(
   parameter int DEPTH       = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valE,
   input  logic [63:0] valA,
   input  logic [63:0] valP,
   input  logic        init_we,
   input  logic [63:0] init_addr,
   input  logic [63:0] init_data,
   output logic        busy,
   output logic        done,
   output logic [63:0] valM,
   output logic        dmem_error
);

   localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int          CNT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'd8;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [63:0]        mem [DEPTH];

   logic               op_rd, op_wr, op_flt;
   logic [63:0]        op_addr, op_wdata;
   logic               accept, go_access, last_access;

   logic               rd_q, wr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [63:0]        wdata_q;

   // Unsigned byte address must be 8-byte aligned and inside the array.
   function automatic logic addr_fault(input logic [63:0] addr);
      return (addr[2:0] != 3'b000) || (addr >= BYTE_LIMIT);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr);
      return IDX_W'(addr >> 3);
   endfunction

   // Decode icode into read/write intent, effective address and store data.
   always_comb begin
      op_rd    = 1'b0;
      op_wr    = 1'b0;
      op_addr  = valE;
      op_wdata = valA;
      case (icode)
         4'h4: op_wr = 1'b1;
         4'h5: op_rd = 1'b1;
         4'h8: begin op_wr = 1'b1; op_wdata = valP; end
         4'h9: begin op_rd = 1'b1; op_addr = valA; end
         4'hA: op_wr = 1'b1;
         4'hB: begin op_rd = 1'b1; op_addr = valA; end
         default: ;
      endcase
      op_flt = addr_fault(op_addr);
   end

   assign accept      = (state == IDLE) && start;
   assign go_access   = accept && (op_rd || op_wr) && !op_flt;
   assign last_access = (state == ACCESS) && (cnt == '0);
   assign busy        = (state != IDLE);
   assign done        = (state == RESP);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: faults and no-access ops skip straight to RESP.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = go_access ? ACCESS : RESP;
         ACCESS:  if (cnt == '0) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Capture the accepted op so inputs need only be valid on the accept edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         rd_q    <= op_rd;
         wr_q    <= op_wr;
         idx_q   <= word_idx(op_addr);
         wdata_q <= op_wdata;
      end
   end

   // Latency counter and the result registers held until the next completion.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         valM       <= '0;
         dmem_error <= 1'b0;
      end else if (accept) begin
         cnt <= CNT_W'(MEM_LATENCY - 1);
         if (!go_access) begin
            valM       <= '0;
            dmem_error <= (op_rd || op_wr) && op_flt;
         end
      end else if (state == ACCESS) begin
         if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end else begin
            valM       <= rd_q ? mem[idx_q] : '0;
            dmem_error <= 1'b0;
         end
      end
   end

   // Memory writes: op store on the final ACCESS edge, else idle preload.
   // Gating on rst_n drops a store that is in flight when reset arrives.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (last_access && wr_q)
            mem[idx_q] <= wdata_q;
         else if ((state == IDLE) && !start && init_we && !addr_fault(init_addr))
            mem[word_idx(init_addr)] <= init_data;
      end
   end

endmodule
